// File: rtl/fifo_reg.sv
// -----------------------------------------------------------------------------
// fifo_reg
//   First-in first-out register queue built as a circular buffer with
//   independent write (tail) and read (head) pointers that wrap at DEPTH.
//   Popped data is registered. Rejected pushes (full) and rejected pops
//   (empty) are reported with one-cycle pulses rather than dropped silently.
//
// Parameters
//   DEPTH : number of entries (>= 2, any integer, not only powers of 2)
//   WIDTH : data width in bits
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   reset_i      : asynchronous active-low reset (0 = reset, 1 = run)
//   push_i       : write din_i to the tail of the queue
//   din_i        : data to push
//   pop_i        : read the entry at the head of the queue
//   dout_o       : registered popped data, holds until the next accepted pop
//   dout_valid_o : one-cycle pulse, dout_o was updated by the previous edge
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
//   count_o      : number of occupied entries, 0..DEPTH
//   overflow_o   : one-cycle pulse, a push was rejected
//   underflow_o  : one-cycle pulse, a pop was rejected
// -----------------------------------------------------------------------------
module fifo_reg #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       dout_valid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_pop_acc;
    logic             w_push_acc;

    // Explicit wrap at DEPTH-1 so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A push into a full queue is still legal when a pop frees a slot on the
    // same edge. A push into an empty queue never satisfies a same-cycle pop.
    assign w_pop_acc  = pop_i && !w_empty;
    assign w_push_acc = push_i && (!w_full || w_pop_acc);

    // Storage is deliberately not reset; the pointers make stale data unreachable.
    always_ff @(posedge clk_i) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_dout_valid <= w_pop_acc;
            r_overflow   <= push_i && !w_push_acc;
            r_underflow  <= pop_i && !w_pop_acc;

            if (w_push_acc) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end

            // On a full push+pop the write targets the slot being read; the
            // read sees the old entry because both are non-blocking.
            if (w_pop_acc) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end

            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout_o       = r_dout;
    assign dout_valid_o = r_dout_valid;
    assign full_o       = w_full;
    assign empty_o      = w_empty;
    assign count_o      = r_count;
    assign overflow_o   = r_overflow;
    assign underflow_o  = r_underflow;

endmodule

// File: tb/tb_fifo_reg.sv
// -----------------------------------------------------------------------------
// tb_fifo_reg
//   Self-checking bench for fifo_reg. A queue-based model predicts every
//   output after each clock step; directed steps cover the named scenarios and
//   a randomized run follows.
// -----------------------------------------------------------------------------
module tb_fifo_reg;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk_i;
    logic             reset_i;
    logic             push_i;
    logic [WIDTH-1:0] din_i;
    logic             pop_i;
    logic [WIDTH-1:0] dout_o;
    logic             dout_valid_o;
    logic             full_o;
    logic             empty_o;
    logic [CW-1:0]    count_o;
    logic             overflow_o;
    logic             underflow_o;

    fifo_reg #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_i       (push_i),
        .din_i        (din_i),
        .pop_i        (pop_i),
        .dout_o       (dout_o),
        .dout_valid_o (dout_valid_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_vld;
    logic             m_of;
    logic             m_uf;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"},  32'(dout_o),       32'(m_dout));
        chk({tag, ".vld"},   32'(dout_valid_o), 32'(m_vld));
        chk({tag, ".count"}, 32'(count_o),      32'(q.size()));
        chk({tag, ".full"},  32'(full_o),       32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty_o),      32'(q.size() == 0));
        chk({tag, ".ovf"},   32'(overflow_o),   32'(m_of));
        chk({tag, ".udf"},   32'(underflow_o),  32'(m_uf));
    endtask

    // Apply one cycle of stimulus, predict from queue rules, then check.
    task automatic step(input string tag, input logic push, input logic [WIDTH-1:0] din,
                        input logic pop);
        bit pop_ok;
        bit push_ok;
        push_i = push;
        din_i  = din;
        pop_i  = pop;
        pop_ok  = pop && (q.size() > 0);
        push_ok = push && ((q.size() < DEPTH) || pop_ok);
        @(posedge clk_i);
        #1;
        m_uf  = pop && !pop_ok;
        m_of  = push && !push_ok;
        m_vld = pop_ok;
        if (pop_ok)  m_dout = q.pop_front();
        if (push_ok) q.push_back(din);
        push_i = 1'b0;
        pop_i  = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_vld  = 1'b0;
        m_of   = 1'b0;
        m_uf   = 1'b0;
    endtask

    initial begin
        reset_i = 1'b0;
        push_i  = 1'b0;
        pop_i   = 1'b0;
        din_i   = '0;
        model_reset();
        #2;
        check_all("reset");
        #5;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_all("release");

        // Basic ordering
        step("b_push", 1'b1, 8'h11, 1'b0);
        step("b_push", 1'b1, 8'h22, 1'b0);
        step("b_push", 1'b1, 8'h33, 1'b0);
        for (int i = 0; i < 3; i++) step("b_pop", 1'b0, 8'h00, 1'b1);
        chk("b_last_dout", 32'(dout_o), 32'h33);
        step("b_idle", 1'b0, 8'h00, 1'b0);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step("f_push", 1'b1, 8'(i), 1'b0);
        chk("f_full", 32'(full_o), 32'd1);
        step("f_ovf", 1'b1, 8'hAA, 1'b0);
        chk("f_ovf_pulse", 32'(overflow_o), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step("f_pop", 1'b0, 8'h00, 1'b1);
            chk("f_order", 32'(dout_o), 32'(i));
        end

        // Pointer wrap
        for (int i = 0; i < 5; i++) step("w_push5", 1'b1, 8'(8'hE0 + i), 1'b0);
        for (int i = 0; i < 5; i++) step("w_pop5", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) step("w_push8", 1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            step("w_pop8", 1'b0, 8'h00, 1'b1);
            chk("w_order", 32'(dout_o), 32'(8'h40 + i));
        end

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step("s_fill", 1'b1, 8'(8'h80 + i), 1'b0);
        step("s_both", 1'b1, 8'h99, 1'b1);
        chk("s_oldest", 32'(dout_o), 32'h80);
        chk("s_cnt", 32'(count_o), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) step("s_drain", 1'b0, 8'h00, 1'b1);
        chk("s_last", 32'(dout_o), 32'h99);

        // Empty with simultaneous push and pop
        step("e_both", 1'b1, 8'h5A, 1'b1);
        chk("e_udf", 32'(underflow_o), 32'd1);
        step("e_pop", 1'b0, 8'h00, 1'b1);
        chk("e_data", 32'(dout_o), 32'h5A);

        // Mid-cycle asynchronous reset
        step("r_push", 1'b1, 8'hC1, 1'b0);
        step("r_push", 1'b1, 8'hC2, 1'b0);
        step("r_push", 1'b1, 8'hC3, 1'b0);
        step("r_pop", 1'b0, 8'h00, 1'b1);
        #2;
        reset_i = 1'b0;
        #1;
        model_reset();
        check_all("r_async");
        #3;
        reset_i = 1'b1;
        step("r_udf", 1'b0, 8'h00, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
